// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM state type and a digit-validity helper for the
// digit-serial BCD adder/subtractor.
package bcd_pkg;

  localparam int          BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;
  localparam logic [4:0]  BCD_TEN = 5'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_bcd(input logic [BCD_W-1:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One decimal digit of add or nine's-complement subtract with decimal carry.
// Purely combinational; the serial top feeds it one digit per clock.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a_i,
  input  logic [BCD_W-1:0] b_i,
  input  logic             cin,
  input  logic             sub,
  output logic [BCD_W-1:0] digit,
  output logic             cout,
  output logic             digit_err
);

  logic [BCD_W-1:0] w_opb;
  logic [BCD_W:0]   w_t;
  logic [BCD_W:0]   w_adj;

  // Subtraction adds the nine's complement; the initial carry of 1 makes it ten's.
  assign w_opb     = sub ? (BCD_MAX - b_i) : b_i;
  assign w_t       = {1'b0, a_i} + {1'b0, w_opb} + {{BCD_W{1'b0}}, cin};
  assign w_adj     = w_t - BCD_TEN;
  assign cout      = (w_t > {1'b0, BCD_MAX});
  assign digit     = cout ? w_adj[BCD_W-1:0] : w_t[BCD_W-1:0];
  assign digit_err = ~is_bcd(a_i) | ~is_bcd(b_i);

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD adder/subtractor: captures packed BCD operands on start,
// processes one digit per clock LSD first, then pulses done with the result.
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode_sub,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  negative,
  output logic                  error
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t              r_state;
  logic [4*DIGITS-1:0] r_a;
  logic [4*DIGITS-1:0] r_b;
  logic [4*DIGITS-1:0] r_sum;
  logic [IDX_W-1:0]    r_idx;
  logic                r_carry;
  logic                r_sub;
  logic                r_busy;
  logic                r_done;
  logic                r_cout;
  logic                r_neg;
  logic                r_err;

  logic [DIGITS-1:0]   w_dig_bad;
  logic                w_in_err;
  logic [BCD_W-1:0]    w_a_dig;
  logic [BCD_W-1:0]    w_b_dig;
  logic [BCD_W-1:0]    w_digit;
  logic                w_cout;
  logic                w_dig_err;

  for (genvar g = 0; g < DIGITS; g++) begin : g_chk
    assign w_dig_bad[g] = ~is_bcd(a[g*BCD_W +: BCD_W]) | ~is_bcd(b[g*BCD_W +: BCD_W]);
  end
  assign w_in_err = |w_dig_bad;

  assign w_a_dig = r_a[int'(r_idx)*BCD_W +: BCD_W];
  assign w_b_dig = r_b[int'(r_idx)*BCD_W +: BCD_W];

  bcd_digit_adder u_digit (
    .a_i       (w_a_dig),
    .b_i       (w_b_dig),
    .cin       (r_carry),
    .sub       (r_sub),
    .digit     (w_digit),
    .cout      (w_cout),
    .digit_err (w_dig_err)
  );

  // Operands are only held for the datapath; they need no reset value.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && start) begin
      r_a <= a;
      r_b <= b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_neg   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sub   <= mode_sub;
            r_carry <= mode_sub | cin;
            r_sum   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_cout  <= 1'b0;
            r_neg   <= 1'b0;
            r_err   <= w_in_err;
            r_state <= w_in_err ? DONE : RUN;
          end
        end
        RUN: begin
          r_sum[int'(r_idx)*BCD_W +: BCD_W] <= w_digit;
          r_carry <= w_cout;
          r_err   <= r_err | w_dig_err;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) r_state <= DONE;
        end
        DONE: begin
          // The error path never ran, so r_carry still holds the captured cin.
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_cout  <= ~r_err & r_carry;
          r_neg   <= ~r_err & r_sub & ~r_carry;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign negative = r_neg;
  assign error    = r_err;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Bench for bcd_addsub_serial: decimal-arithmetic model checked every cycle on a
// 2-digit instance, plus literal cases on 2-, 4- and 1-digit instances.
module tb_bcd_addsub_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // 2-digit instance
  logic       start2 = 0, mode2 = 0, cin2 = 0;
  logic [7:0] a2 = 0, b2 = 0;
  logic       busy2, done2, cout2, neg2, err2;
  logic [7:0] sum2;

  bcd_addsub_serial #(.DIGITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode_sub(mode2), .cin(cin2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .sum(sum2),
    .cout(cout2), .negative(neg2), .error(err2)
  );

  // 4-digit instance
  logic        start4 = 0, mode4 = 0, cin4 = 0;
  logic [15:0] a4 = 0, b4 = 0;
  logic        busy4, done4, cout4, neg4, err4;
  logic [15:0] sum4;

  bcd_addsub_serial #(.DIGITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode_sub(mode4), .cin(cin4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .sum(sum4),
    .cout(cout4), .negative(neg4), .error(err4)
  );

  // 1-digit instance
  logic       start1 = 0, mode1 = 0, cin1 = 0;
  logic [3:0] a1 = 0, b1 = 0;
  logic       busy1, done1, cout1, neg1, err1;
  logic [3:0] sum1;

  bcd_addsub_serial #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode_sub(mode1), .cin(cin1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .sum(sum1),
    .cout(cout1), .negative(neg1), .error(err1)
  );

  function automatic bit bad2(input logic [7:0] v);
    return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
  endfunction

  function automatic int to_int2(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd2(input int v);
    logic [7:0] r;
    r[7:4] = 4'((v / 10) % 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // Reference model for the 2-digit instance: whole-number arithmetic modulo 100
  // and a cycle countdown from acceptance to the done pulse.
  logic       m_busy = 0, m_done = 0, m_chk = 1;
  logic [7:0] m_sum = 0;
  logic       m_cout = 0, m_neg = 0, m_err = 0;
  logic [7:0] p_sum = 0;
  logic       p_cout = 0, p_neg = 0, p_err = 0;
  int         m_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; m_done = 0; m_chk = 1; m_cnt = 0;
        m_sum = 0; m_cout = 0; m_neg = 0; m_err = 0;
      end
      chk("busy", busy2, m_busy);
      chk("done", done2, m_done);
      if (m_chk) begin
        chk("sum", sum2, m_sum);
        chk("cout", cout2, m_cout);
        chk("negative", neg2, m_neg);
        chk("error", err2, m_err);
      end
      if (rst_n) begin
        m_done = 0;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_done = 1; m_busy = 0; m_chk = 1;
            m_sum = p_sum; m_cout = p_cout; m_neg = p_neg; m_err = p_err;
          end
        end else if (start2) begin
          m_busy = 1; m_chk = 0;
          if (bad2(a2) || bad2(b2)) begin
            p_sum = 0; p_cout = 0; p_neg = 0; p_err = 1; m_cnt = 1;
          end else begin
            int v;
            v = mode2 ? (to_int2(a2) - to_int2(b2) + 100) : (to_int2(a2) + to_int2(b2) + int'(cin2));
            p_cout = (v >= 100);
            p_sum  = to_bcd2(v % 100);
            p_neg  = mode2 & ~p_cout;
            p_err  = 0;
            m_cnt  = 3;
          end
        end
      end
    end
  end

  // Drives one request on the 2-digit instance; lat counts clock edges from the
  // accepting edge through the edge that raises done (DIGITS+2 for a normal run).
  task automatic go2(input logic [7:0] ta, input logic [7:0] tb, input logic tsub, input logic tcin,
                     input logic poke, output int lat);
    @(posedge clk); #1;
    a2 = ta; b2 = tb; mode2 = tsub; cin2 = tcin; start2 = 1;
    @(posedge clk); #1;
    start2 = 0; lat = 1;
    if (poke) begin
      a2 = 8'h11; b2 = 8'h11; mode2 = ~tsub; start2 = 1;
    end
    while (!done2 && lat < 20) begin
      @(posedge clk); #1;
      start2 = 0;
      lat++;
    end
    chk("done2_seen", done2, 1'b1);
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy2, 1'b0);
    chk("rst_sum", sum2, 8'h00);
    rst_n = 1;

    go2(8'h47, 8'h38, 0, 0, 0, lat);
    chk("add47_38_sum", sum2, 8'h85); chk("add47_38_cout", cout2, 0);
    chk("add47_38_err", err2, 0);     chk("add47_38_lat", lat, 4);

    go2(8'h99, 8'h99, 0, 1, 0, lat);
    chk("add99_99_sum", sum2, 8'h99); chk("add99_99_cout", cout2, 1);

    go2(8'h50, 8'h27, 1, 0, 0, lat);
    chk("sub50_27_sum", sum2, 8'h23); chk("sub50_27_cout", cout2, 1);
    chk("sub50_27_neg", neg2, 0);

    go2(8'h27, 8'h50, 1, 1, 0, lat);
    chk("sub27_50_sum", sum2, 8'h77); chk("sub27_50_cout", cout2, 0);
    chk("sub27_50_neg", neg2, 1);

    go2(8'h1A, 8'h05, 0, 1, 0, lat);
    chk("err_flag", err2, 1); chk("err_sum", sum2, 8'h00);
    chk("err_cout", cout2, 0); chk("err_lat", lat, 2);

    go2(8'h12, 8'h34, 0, 0, 0, lat);
    chk("clr_err", err2, 0); chk("clr_sum", sum2, 8'h46);

    go2(8'h47, 8'h38, 0, 0, 1, lat);
    chk("poke_sum", sum2, 8'h85); chk("poke_lat", lat, 4);

    // Reset in the middle of a run.
    @(posedge clk); #1;
    a2 = 8'h47; b2 = 8'h38; mode2 = 0; cin2 = 0; start2 = 1;
    @(posedge clk); #1;
    start2 = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("midrst_busy", busy2, 0); chk("midrst_sum", sum2, 8'h00);
    chk("midrst_done", done2, 0);
    @(posedge clk); #1;
    rst_n = 1;
    go2(8'h12, 8'h34, 0, 1, 0, lat);
    chk("afterrst_sum", sum2, 8'h47); chk("afterrst_lat", lat, 4);

    // 4-digit instance
    @(posedge clk); #1;
    a4 = 16'h9999; b4 = 16'h0001; mode4 = 0; cin4 = 0; start4 = 1;
    @(posedge clk); #1;
    start4 = 0; lat = 1;
    while (!done4 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("d4_done", done4, 1); chk("d4_sum", sum4, 16'h0000);
    chk("d4_cout", cout4, 1); chk("d4_lat", lat, 6);

    // 1-digit instance
    @(posedge clk); #1;
    a1 = 4'h5; b1 = 4'h5; mode1 = 0; cin1 = 0; start1 = 1;
    @(posedge clk); #1;
    start1 = 0; lat = 1;
    while (!done1 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("d1_done", done1, 1); chk("d1_sum", sum1, 4'h0);
    chk("d1_cout", cout1, 1); chk("d1_lat", lat, 3);

    // Randomised traffic on the 2-digit instance, including starts while busy,
    // invalid digits and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst_n  = ($urandom_range(0, 399) != 0);
      start2 = ($urandom_range(0, 2) == 0);
      mode2  = $urandom_range(0, 1);
      cin2   = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) a2 = 8'($urandom_range(0, 255));
      else a2 = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 15) == 0) b2 = 8'($urandom_range(0, 255));
      else b2 = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    end
    @(posedge clk); #1;
    rst_n = 1; start2 = 0;
    repeat (6) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
